arith_index_cast_buf: RTL and testbench
=======================================

Name: arith_index_cast_buf

Overview:
Elastic, handshaked index-width converter for streaming index values between dataflow stages of different index widths. Each accepted input is converted once, by sign or zero extension or by truncation. Truncation that loses information is flagged per beat and tallied in a saturating counter. Results are held in a small FIFO, so producer and consumer stall independently.

Parameters:
IN_WIDTH, 64, input index width in bits (>=1)
OUT_WIDTH, 32, output index width in bits (>=1)
SIGNED, 1, 1 = sign-extend and signed range check; 0 = zero-extend and unsigned range check
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has data
in_ready  output  1  block accepts data
in_data  input  IN_WIDTH  source index
out_valid  output  1  converted data available
out_ready  input  1  consumer accepts data
out_data  output  OUT_WIDTH  converted index
out_trunc  output  1  beat lost information during conversion
ovf_count  output  16  saturating count of accepted truncating beats
ovf_clear  input  1  synchronous clear of ovf_count

Behaviour:
- Reset: clears the FIFO. Outputs go to out_valid=0, out_data=0, out_trunc=0, ovf_count=0. in_ready=1 from the first cycle after reset deasserts. Reset may be asserted mid-transfer; all in-flight beats are discarded.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = !full and does not depend on out_ready. A full FIFO refuses input even when a pop happens in the same cycle.
  - out_valid = !empty. out_data and out_trunc come straight from the FIFO head register, with no combinational path from in_data.
  - out_valid, out_data and out_trunc stay stable while out_valid && !out_ready.
- Latency: a beat pushed in cycle N can be popped in cycle N+1 at the earliest. Sustained throughput is 1 beat/cycle when DEPTH>=2 and out_ready=1.
- Conversion, done at push time:
  - OUT_WIDTH > IN_WIDTH: upper bits are copies of in_data[IN_WIDTH-1] when SIGNED=1, zeros when SIGNED=0. trunc=0.
  - OUT_WIDTH == IN_WIDTH: pass-through, trunc=0.
  - OUT_WIDTH < IN_WIDTH: result = in_data[OUT_WIDTH-1:0].
    - SIGNED=0: trunc = OR of in_data[IN_WIDTH-1:OUT_WIDTH].
    - SIGNED=1: trunc = 1 unless every bit of in_data[IN_WIDTH-1:OUT_WIDTH-1] is equal.
- FIFO: read/write pointers are log2(DEPTH)+1 bits wide, with the extra bit used for the wrap flag. full = addresses equal and wrap bits differ. empty = pointers equal. Pointers wrap modulo 2*DEPTH.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, both pointers advance.
- ovf_count:
  - Increments on each push with trunc=1.
  - Saturates at 16'hFFFF.
  - ovf_clear in the same cycle as an increment forces 0; clear wins.
  - Counts at push, not at pop.

Optional Feature:
ARITH_INDEX_CAST_SAT_EN
- Defined: a truncating conversion saturates instead of wrapping.
  - SIGNED=0: result = all ones.
  - SIGNED=1: result = 2^(OUT_WIDTH-1)-1 for a non-negative input, -2^(OUT_WIDTH-1) for a negative input.
  - trunc and ovf_count behave exactly as without the macro.
- Undefined: truncation wraps (low bits kept) as described under Behaviour. No saturation logic is instantiated.

Test Plan:
1. IN=64, OUT=32, SIGNED=1: push 64'hFFFF_FFFF_FFFF_FFFE -> out_data=32'hFFFF_FFFE, out_trunc=0. Push 64'h0000_0001_0000_0000 -> out_data=0, out_trunc=1, ovf_count=1. With SAT_EN the same push gives out_data=32'h7FFF_FFFF.
2. IN=16, OUT=32: SIGNED=1, push 16'h8001 -> 32'hFFFF_8001. SIGNED=0, push 16'h8001 -> 32'h0000_8001. out_trunc=0 in both cases.
3. DEPTH=2, out_ready=0: push 3 beats A,B,C -> A and B accepted, in_ready=0 after 2 pushes, C held. Raise out_ready -> A, B, C emerge in order with stable data while stalled.
4. in_valid and out_ready held at 1 for 100 cycles with an incrementing pattern -> 1 beat/cycle after the first-cycle latency, no drops, no duplicates, in-order.
5. Push 3 truncating beats with ovf_clear asserted on the 3rd push cycle -> ovf_count=0 after that cycle. Separately, preload the count near 16'hFFFF and push more truncating beats -> holds at 16'hFFFF.
6. Assert rst while 2 beats are queued and out_ready=0 -> out_valid=0, out_data=0, out_trunc=0, ovf_count=0 immediately. in_ready=1 after reset releases.

Source files
------------

// File: rtl/arith_index_cast_buf.sv
// arith_index_cast_buf: elastic index-width converter with a small result FIFO.
// Each accepted beat is converted once (extend, pass-through or truncate) at push
// time; lossy truncations are flagged per beat and tallied in a saturating counter.
// Optional macro ARITH_INDEX_CAST_SAT_EN: lossy truncations saturate instead of wrap.
module arith_index_cast_buf #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32,
  parameter int SIGNED    = 1,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_trunc,
  output logic [15:0]          ovf_count,
  input  logic                 ovf_clear
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [OUT_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]     trunc_mem;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [OUT_WIDTH-1:0] conv_data;
  logic                 conv_trunc;

  // Conversion of the incoming index, selected by the relative widths.
  generate
    if (OUT_WIDTH > IN_WIDTH) begin : g_widen
      localparam int EXT = OUT_WIDTH - IN_WIDTH;
      logic ext_bit;
      assign ext_bit    = (SIGNED != 0) ? in_data[IN_WIDTH-1] : 1'b0;
      assign conv_data  = {{EXT{ext_bit}}, in_data};
      assign conv_trunc = 1'b0;
    end else if (OUT_WIDTH == IN_WIDTH) begin : g_pass
      assign conv_data  = in_data;
      assign conv_trunc = 1'b0;
    end else begin : g_narrow
      logic [OUT_WIDTH-1:0] low_bits;
      assign low_bits = in_data[OUT_WIDTH-1:0];

      if (SIGNED != 0) begin : g_signed_chk
        // The dropped bits plus the new sign bit must all match the old sign.
        logic [IN_WIDTH-OUT_WIDTH:0] sign_field;
        assign sign_field = in_data[IN_WIDTH-1:OUT_WIDTH-1];
        assign conv_trunc = !((&sign_field) || !(|sign_field));
      end else begin : g_unsigned_chk
        assign conv_trunc = |in_data[IN_WIDTH-1:OUT_WIDTH];
      end

`ifdef ARITH_INDEX_CAST_SAT_EN
      logic [OUT_WIDTH-1:0] sat_data;
      // Clamp value: all ones when unsigned, otherwise max positive or min negative.
      always_comb begin
        sat_data = '1;
        if (SIGNED != 0) begin
          sat_data = {OUT_WIDTH{~in_data[IN_WIDTH-1]}};
          sat_data[OUT_WIDTH-1] = in_data[IN_WIDTH-1];
        end
      end
      assign conv_data = conv_trunc ? sat_data : low_bits;
`else
      assign conv_data = low_bits;
`endif
    end
  endgenerate

  // Pointer MSB is the wrap flag; equal addresses with differing wrap means full.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = data_mem[rd_ptr[AW-1:0]];
  assign out_trunc = trunc_mem[rd_ptr[AW-1:0]];

  // Storage: converted beats are written at the write pointer; reset clears all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
      end
      trunc_mem <= '0;
    end else if (push) begin
      data_mem[wr_ptr[AW-1:0]]  <= conv_data;
      trunc_mem[wr_ptr[AW-1:0]] <= conv_trunc;
    end
  end

  // Pointer update: each pointer advances independently on its own handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Lossy-beat counter: counts at push, saturates, and a clear beats an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= 16'd0;
    end else if (ovf_clear) begin
      ovf_count <= 16'd0;
    end else if (push && conv_trunc && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_arith_index_cast_buf.sv
// Bench for arith_index_cast_buf: scoreboard-checked 64->32 signed instance plus
// two 16->32 instances for sign/zero extension.
module tb_arith_index_cast_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_trunc;
  logic [15:0] ovf_count;
  logic        ovf_clear;

  logic        ws_in_valid, ws_in_ready, ws_out_valid, ws_out_trunc;
  logic [15:0] ws_in_data;
  logic [31:0] ws_out_data;
  logic [15:0] ws_ovf_count;
  logic        wu_in_valid, wu_in_ready, wu_out_valid, wu_out_trunc;
  logic [15:0] wu_in_data;
  logic [31:0] wu_out_data;
  logic [15:0] wu_ovf_count;
  logic        w_out_ready;
  logic        w_ovf_clear;

  int          errors = 0;
  int          checks = 0;
  int          push_cnt = 0;
  int          pop_cnt = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_beat;

  arith_index_cast_buf #(.IN_WIDTH(64), .OUT_WIDTH(32), .SIGNED(1), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_trunc(out_trunc),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  arith_index_cast_buf #(.IN_WIDTH(16), .OUT_WIDTH(32), .SIGNED(1), .DEPTH(2)) dut_ws (
    .clk(clk), .rst(rst), .in_valid(ws_in_valid), .in_ready(ws_in_ready), .in_data(ws_in_data),
    .out_valid(ws_out_valid), .out_ready(w_out_ready), .out_data(ws_out_data),
    .out_trunc(ws_out_trunc), .ovf_count(ws_ovf_count), .ovf_clear(w_ovf_clear)
  );

  arith_index_cast_buf #(.IN_WIDTH(16), .OUT_WIDTH(32), .SIGNED(0), .DEPTH(2)) dut_wu (
    .clk(clk), .rst(rst), .in_valid(wu_in_valid), .in_ready(wu_in_ready), .in_data(wu_in_data),
    .out_valid(wu_out_valid), .out_ready(w_out_ready), .out_data(wu_out_data),
    .out_trunc(wu_out_trunc), .ovf_count(wu_ovf_count), .ovf_clear(w_ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion for the 64->32 signed instance, via signed range test.
  function automatic logic [32:0] model(input logic [63:0] x);
    longint     sx;
    logic       t;
    logic [31:0] d;
    sx = longint'(x);
    t  = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
    d  = x[31:0];
`ifdef ARITH_INDEX_CAST_SAT_EN
    if (t) d = (sx < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {t, d};
  endfunction

  // Scoreboard monitor: sampled just before each rising edge, pops checked before pushes.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL pop_unexpected: got data=%h trunc=%b, required no beat", out_data, out_trunc);
        end else begin
          exp_beat = sb.pop_front();
          if ({out_trunc, out_data} !== exp_beat) begin
            errors++;
            $display("[TB] FAIL pop_data: got trunc=%b data=%h, required trunc=%b data=%h",
                     out_trunc, out_data, exp_beat[32], exp_beat[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        push_cnt++;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    ws_in_valid = 1'b0;
    wu_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, out_trunc} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid/trunc=%b, required 00", {out_valid, out_trunc});
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h, required 0", out_data);
    end
    checks++;
    if (ovf_count !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %h, required 0", ovf_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_convert();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    in_data = 64'h0000_0001_0000_0000;
    #1;
    checks++;
    if ({out_trunc, out_data} !== {1'b0, 32'hFFFF_FFFE}) begin
      errors++;
      $display("[TB] FAIL convert_neg: got trunc=%b data=%h, required 0 fffffffe", out_trunc, out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
`ifdef ARITH_INDEX_CAST_SAT_EN
    if ({out_trunc, out_data} !== {1'b1, 32'h7FFF_FFFF}) begin
`else
    if ({out_trunc, out_data} !== {1'b1, 32'h0000_0000}) begin
`endif
      errors++;
      $display("[TB] FAIL convert_trunc: got trunc=%b data=%h", out_trunc, out_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ovf_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL convert_ovf: got %0d, required 1", ovf_count);
    end
  endtask

  task automatic test_widen();
    do_reset();
    w_out_ready = 1'b1;
    ws_in_valid = 1'b1;
    ws_in_data = 16'h8001;
    wu_in_valid = 1'b1;
    wu_in_data = 16'h8001;
    @(negedge clk);
    ws_in_valid = 1'b0;
    wu_in_valid = 1'b0;
    #1;
    checks++;
    if ({ws_out_valid, ws_out_trunc, ws_out_data} !== {1'b1, 1'b0, 32'hFFFF_8001}) begin
      errors++;
      $display("[TB] FAIL widen_signed: got v=%b t=%b d=%h, required 1 0 ffff8001",
               ws_out_valid, ws_out_trunc, ws_out_data);
    end
    checks++;
    if ({wu_out_valid, wu_out_trunc, wu_out_data} !== {1'b1, 1'b0, 32'h0000_8001}) begin
      errors++;
      $display("[TB] FAIL widen_unsigned: got v=%b t=%b d=%h, required 1 0 00008001",
               wu_out_valid, wu_out_trunc, wu_out_data);
    end
  endtask

  task automatic test_stall();
    int p0;
    int q0;
    int n;
    do_reset();
    p0 = push_cnt;
    q0 = pop_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h0000_0000_0000_0005;
    @(negedge clk);
    in_data = 64'hFFFF_FFFF_8000_0000;
    @(negedge clk);
    in_data = 64'h0000_0000_8000_0000;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_in_ready: got %b, required 0", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, out_trunc, out_data} !== {1'b1, 1'b0, 32'h5}) begin
        errors++;
        $display("[TB] FAIL stall_hold: got v=%b t=%b d=%h, required 1 0 00000005",
                 out_valid, out_trunc, out_data);
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (push_cnt - p0 !== 2) begin
      errors++;
      $display("[TB] FAIL stall_accepted: got %0d, required 2", push_cnt - p0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((pop_cnt - q0 !== 3) || (push_cnt - p0 !== 3) || out_valid) begin
      errors++;
      $display("[TB] FAIL stall_drain: got pushes=%0d pops=%0d valid=%b, required 3 3 0",
               push_cnt - p0, pop_cnt - q0, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    int q0;
    do_reset();
    p0 = push_cnt;
    q0 = pop_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data = 64'h0000_0000_7FFF_FFF0 + 64'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if ((push_cnt - p0 !== 100) || (pop_cnt - q0 !== 99)) begin
      errors++;
      $display("[TB] FAIL b2b_throughput: got pushes=%0d pops=%0d, required 100 99",
               push_cnt - p0, pop_cnt - q0);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ovf_count !== 16'd84) begin
      errors++;
      $display("[TB] FAIL b2b_ovf: got %0d, required 84", ovf_count);
    end
    checks++;
    if ((sb.size() != 0) || out_valid) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got pending=%0d valid=%b, required 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_ovf();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 64'h0000_0001_0000_0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (ovf_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL ovf_pre_clear: got %0d, required 2", ovf_count);
    end
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (ovf_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL ovf_clear_wins: got %0d, required 0", ovf_count);
    end
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 64'h8000_0000_0000_0000;
    repeat (65533) @(negedge clk);
    #1;
    checks++;
    if (ovf_count !== 16'hFFFD) begin
      errors++;
      $display("[TB] FAIL ovf_preload: got %h, required fffd", ovf_count);
    end
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (ovf_count !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL ovf_saturate: got %h, required ffff", ovf_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h0000_0001_0000_0005;
    @(negedge clk);
    in_data = 64'h0000_0000_0000_0007;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, ovf_count} !== {1'b1, 1'b0, 16'd1}) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got v=%b rdy=%b ovf=%0d, required 1 0 1", out_valid, in_ready, ovf_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_trunc, out_data, ovf_count} !== {2'b00, 32'h0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got v=%b t=%b d=%h ovf=%h, required all 0",
               out_valid, out_trunc, out_data, ovf_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midrst_release: got rdy=%b v=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  // Test sequence.
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    ws_in_valid = 1'b0;
    ws_in_data = '0;
    wu_in_valid = 1'b0;
    wu_in_data = '0;
    w_out_ready = 1'b1;
    w_ovf_clear = 1'b0;
    test_reset();
    test_convert();
    test_widen();
    test_stall();
    test_back_to_back();
    test_ovf();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
